// File: rtl/fetch_bubble_injector_pkg.sv
// Shared pipeline definitions for the fetch/stage-2 boundary: state encodings,
// default widths and the bubble encoding used by the hazard unit and stage registers.
package fetch_bubble_injector_pkg;

  localparam int unsigned DEF_IW = 16;
  localparam int unsigned DEF_AW = 8;
  localparam logic [DEF_IW-1:0] DEF_NOP_WORD = 16'h0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  // Width needed to hold values 0..max inclusive.
  function automatic int unsigned cnt_width(input int unsigned max);
    return (max < 2) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/fetch_bubble_injector_if.sv
// Fetch-side bus: hazard/branch inputs, instruction memory port and stage-2 outputs.
interface fetch_bubble_injector_if
  import fetch_bubble_injector_pkg::*;
#(
  parameter int unsigned IW = DEF_IW,
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned CW = 8
);
  logic          bb;
  logic          br_taken;
  logic [AW-1:0] br_target;
  logic [IW-1:0] if_instr;
  logic [AW-1:0] pc_out;
  logic [IW-1:0] id_instr;
  logic [AW-1:0] id_pc;
  logic          id_valid;
  logic          stall_active;
  logic [CW-1:0] bubble_cnt;
  logic          stall_timeout;

  modport master (
    output bb, br_taken, br_target, if_instr,
    input  pc_out, id_instr, id_pc, id_valid, stall_active, bubble_cnt, stall_timeout
  );

  modport slave (
    input  bb, br_taken, br_target, if_instr,
    output pc_out, id_instr, id_pc, id_valid, stall_active, bubble_cnt, stall_timeout
  );
endinterface

// File: rtl/fetch_bubble_injector_sat_counter.sv
// Saturating up-counter with synchronous clear and synchronous active-low reset.
module sat_counter
  import fetch_bubble_injector_pkg::*;
#(
  parameter int unsigned W   = 8,
  parameter logic [W-1:0] MAX = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                    cnt_d = '0;
    else if (inc && cnt_q != MAX) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/fetch_bubble_injector.sv
// Fetch PC owner and stage-1 -> stage-2 register: freezes fetch and injects NOP bubbles
// on hazard requests, redirects and flushes wrong-path fetches on taken branches.
module fetch_bubble_injector
  import fetch_bubble_injector_pkg::*;
#(
  parameter int unsigned IW           = DEF_IW,
  parameter int unsigned AW           = DEF_AW,
  parameter logic [AW-1:0] RESET_PC   = '0,
  parameter logic [IW-1:0] NOP_WORD   = DEF_NOP_WORD,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned STALL_MAX    = 15,
  parameter int unsigned CW           = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fetch_bubble_injector_if.slave  bus
);
  localparam int unsigned SW = cnt_width(STALL_MAX + 1);
  localparam logic [2:0]    FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [SW-1:0] STALL_SAT  = SW'(STALL_MAX + 1);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] id_instr_q, id_instr_d;
  logic [AW-1:0] id_pc_q, id_pc_d;
  logic          id_valid_q, id_valid_d;
  logic          stall_active_q, stall_active_d;
  logic          stall_timeout_q, stall_timeout_d;
  logic [2:0]    flush_ctr_q, flush_ctr_d;

  logic          bub_inc;
  logic          stall_inc, stall_clr;
  logic [SW-1:0] stall_ctr;
  logic [CW-1:0] bubble_cnt;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    id_instr_d      = id_instr_q;
    id_pc_d         = id_pc_q;
    id_valid_d      = id_valid_q;
    flush_ctr_d     = flush_ctr_q;
    stall_timeout_d = stall_timeout_q;
    bub_inc         = 1'b0;
    stall_inc       = 1'b0;
    stall_clr       = 1'b0;

    if (bus.br_taken) begin
      // Redirect wins over everything, including a coincident bubble request.
      pc_d        = bus.br_target;
      id_instr_d  = NOP_WORD;
      id_valid_d  = 1'b0;
      flush_ctr_d = FLUSH_LOAD;
      state_d     = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
      bub_inc     = 1'b1;
      stall_clr   = 1'b1;
    end else if (state_q == ST_FLUSH) begin
      // Wrong-path words are fetched but never reach stage 2.
      pc_d        = pc_q + AW'(1);
      id_instr_d  = NOP_WORD;
      id_valid_d  = 1'b0;
      flush_ctr_d = (flush_ctr_q == 3'd0) ? 3'd0 : flush_ctr_q - 3'd1;
      state_d     = (flush_ctr_q <= 3'd1) ? ST_RUN : ST_FLUSH;
      bub_inc     = 1'b1;
      stall_clr   = 1'b1;
    end else if (bus.bb) begin
      id_instr_d  = NOP_WORD;
      id_valid_d  = 1'b0;
      state_d     = ST_STALL;
      bub_inc     = 1'b1;
      stall_inc   = 1'b1;
      if (stall_ctr == SW'(STALL_MAX)) stall_timeout_d = 1'b1;
    end else begin
      // RUN, or release from STALL: the held word issues with no extra cycle.
      id_instr_d  = bus.if_instr;
      id_pc_d     = pc_q;
      id_valid_d  = 1'b1;
      pc_d        = pc_q + AW'(1);
      state_d     = ST_RUN;
      stall_clr   = 1'b1;
    end

    stall_active_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_RUN;
      pc_q            <= RESET_PC;
      id_instr_q      <= NOP_WORD;
      id_pc_q         <= '0;
      id_valid_q      <= 1'b0;
      stall_active_q  <= 1'b0;
      stall_timeout_q <= 1'b0;
      flush_ctr_q     <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      id_instr_q      <= id_instr_d;
      id_pc_q         <= id_pc_d;
      id_valid_q      <= id_valid_d;
      stall_active_q  <= stall_active_d;
      stall_timeout_q <= stall_timeout_d;
      flush_ctr_q     <= flush_ctr_d;
    end
  end

  sat_counter #(.W(CW)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bub_inc),
    .clear (1'b0),
    .cnt   (bubble_cnt)
  );

  sat_counter #(.W(SW), .MAX(STALL_SAT)) u_stall_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .clear (stall_clr),
    .cnt   (stall_ctr)
  );

  assign bus.pc_out        = pc_q;
  assign bus.id_instr      = id_instr_q;
  assign bus.id_pc         = id_pc_q;
  assign bus.id_valid      = id_valid_q;
  assign bus.stall_active  = stall_active_q;
  assign bus.bubble_cnt    = bubble_cnt;
  assign bus.stall_timeout = stall_timeout_q;
endmodule

// File: tb/tb_fetch_bubble_injector.sv
// Directed scoreboard bench: each step pushes hand-computed post-edge values; a monitor
// pops one entry per clock edge and compares the registered outputs.
module tb_fetch_bubble_injector;
  localparam int IW = 16;
  localparam int AW = 8;
  localparam int CW = 4;
  localparam logic [IW-1:0] NOP = 16'h0000;

  typedef struct {
    int            idx;
    logic [AW-1:0] pc;
    logic [AW-1:0] id_pc;
    logic          v;
    logic          sa;
    logic [CW-1:0] cnt;
    logic          to;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;
  exp_t sb[$];

  fetch_bubble_injector_if #(.IW(IW), .AW(AW), .CW(CW)) bus ();

  fetch_bubble_injector #(
    .IW(IW), .AW(AW), .RESET_PC(8'h00), .NOP_WORD(NOP),
    .FLUSH_CYCLES(2), .STALL_MAX(15), .CW(CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] rom(input logic [AW-1:0] a);
    return {~a, a};
  endfunction

  assign bus.if_instr = rom(bus.pc_out);

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d actual %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic b, input logic t, input int tgt,
                      input int epc, input int eidpc, input logic ev, input logic esa,
                      input int ecnt, input logic eto);
    exp_t e;
    @(negedge clk);
    rst_n         = r;
    bus.bb        = b;
    bus.br_taken  = t;
    bus.br_target = AW'(tgt);
    e.idx   = step_no;
    e.pc    = AW'(epc);
    e.id_pc = AW'(eidpc);
    e.v     = ev;
    e.sa    = esa;
    e.cnt   = CW'(ecnt);
    e.to    = eto;
    sb.push_back(e);
    step_no++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pc_out", e.idx, 16'(bus.pc_out), 16'(e.pc));
        chk("id_valid", e.idx, 16'(bus.id_valid), 16'(e.v));
        chk("id_instr", e.idx, bus.id_instr, e.v ? rom(e.id_pc) : NOP);
        if (e.v) chk("id_pc", e.idx, 16'(bus.id_pc), 16'(e.id_pc));
        chk("stall_active", e.idx, 16'(bus.stall_active), 16'(e.sa));
        chk("bubble_cnt", e.idx, 16'(bus.bubble_cnt), 16'(e.cnt));
        chk("stall_timeout", e.idx, 16'(bus.stall_timeout), 16'(e.to));
      end
    end
  end

  initial begin : stim
    bus.bb = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_target = '0;
    // reset state
    step(0, 0, 0, 0,    8'h00, 8'h00, 0, 0, 0, 0);
    // straight-line fetch
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, i + 1, i, 1, 0, 0, 0);
    // three-cycle hazard at pc 05, then zero-cycle release
    for (int k = 1; k <= 3; k++) step(1, 1, 0, 0, 8'h05, 0, 0, 1, k, 0);
    step(1, 0, 0, 0,    8'h06, 8'h05, 1, 0, 3, 0);
    // taken branch to 40 with two-bubble flush
    step(1, 0, 1, 8'h40, 8'h40, 0, 0, 1, 4, 0);
    step(1, 0, 0, 0,    8'h41, 0, 0, 0, 5, 0);
    step(1, 0, 0, 0,    8'h42, 8'h41, 1, 0, 5, 0);
    // branch coincident with bb: branch wins, bb ignored during flush
    step(1, 1, 1, 8'h80, 8'h80, 0, 0, 1, 6, 0);
    step(1, 1, 0, 0,    8'h81, 0, 0, 0, 7, 0);
    // 16-cycle hazard: timeout on the 16th edge, bubble_cnt saturates at F
    for (int k = 1; k <= 16; k++)
      step(1, 1, 0, 0, 8'h81, 0, 0, 1, (7 + k > 15) ? 15 : 7 + k, k == 16);
    step(1, 0, 0, 0,    8'h82, 8'h81, 1, 0, 15, 1);
    step(1, 0, 0, 0,    8'h83, 8'h82, 1, 0, 15, 1);
    // reset in the middle of a stall
    step(1, 1, 0, 0,    8'h83, 0, 0, 1, 15, 1);
    step(0, 1, 0, 0,    8'h00, 0, 0, 0, 0, 0);
    // PC wrap FF -> 00
    step(1, 0, 1, 8'hFE, 8'hFE, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0,    8'hFF, 0, 0, 0, 2, 0);
    step(1, 0, 0, 0,    8'h00, 8'hFF, 1, 0, 2, 0);
    step(1, 0, 0, 0,    8'h01, 8'h00, 1, 0, 2, 0);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
